regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Owns the single write port of the 32x32 register file. After reset it runs a clear sequence that writes CLEAR_VALUE to every register, one per cycle. It then shares the write port between two writeback requesters, ALU (requester 0) and load/memory (requester 1), using valid/ready handshakes and round-robin arbitration. It sits between the execute/memory stages and the register file.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, registers cleared by the init sequence (must equal 2**ADDR_W)
CLEAR_VALUE, 0, value written to every register during init

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  load writeback request
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load request accepted this cycle
RegWEn  out  1  register-file write enable (registered)
AddrD  out  ADDR_W  register-file destination address (registered)
DataD  out  DATA_W  register-file write data (registered)
init_done  out  1  high once the clear sequence has completed (registered)

Behaviour:
- Reset (async): state=CLEAR, clr_ptr=0, rr_prio=ALU, RegWEn=0, AddrD=0, DataD=0, init_done=0. All outputs hold these values while rst=1.
- CLEAR state:
  - On each posedge, drive RegWEn=1, AddrD=clr_ptr, DataD=CLEAR_VALUE, then increment clr_ptr.
  - After the edge that issues address NUM_REGS-1, go to RUN and set init_done=1. The clear issues exactly NUM_REGS writes over NUM_REGS cycles.
  - alu_ready=mem_ready=0 throughout CLEAR.
- RUN state, ready logic (combinational from valids, state and rr_prio):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester named by rr_prio gets ready=1; the other gets ready=0.
  - A requester whose valid is low never sees ready=1.
- RUN state, handshake:
  - A transfer occurs when valid&ready at a posedge.
  - Requesters hold addr/data stable while valid=1 and ready=0. valid must not drop before acceptance (protocol rule; the bench asserts it).
- Latency:
  - Accept at edge N: RegWEn/AddrD/DataD carry the accepted request during cycle N..N+1.
  - The register file commits at edge N+1. Effective latency is 1 cycle from acceptance.
  - No transfer at an edge: RegWEn=0 next cycle; AddrD/DataD hold their previous values.
- x0 rule: a transfer with addr=0 is accepted (ready=1, counts as a grant) but RegWEn stays 0 that cycle. x0 is written only by the CLEAR sequence.
- Round-robin update: after any grant in RUN, rr_prio points to the other requester. With no grant, rr_prio is unchanged.
- Throughput: one write per cycle. Continuous dual requests alternate ALU, MEM, ALU, ... with no bubbles.
- Reset mid-operation: an async rst during CLEAR or RUN returns immediately to reset values. CLEAR restarts from address 0. Any write that has not yet committed is dropped.
- No state other than CLEAR/RUN. After the clear completes, RUN is left only via rst.

Decomposition:
- Shared package (regfile_pkg):
  - state typedef {WB_CLEAR, WB_RUN}.
  - requester index constants REQ_ALU=0, REQ_MEM=1.
  - REG_ADDR_W=5, REG_DATA_W=32, REG_X0=0.
- One sub-module: rr_arb2, a 2-way round-robin arbiter.
  - Inputs: req[1:0], grant_taken, prio.
  - Outputs: gnt[1:0], next_prio.
  - Purely combinational; the rr_prio flop stays in the parent.

Test Plan:
- Reset then idle -> RegWEn=1 for exactly 32 consecutive cycles with AddrD=0..31 and DataD=0. init_done rises on the cycle after AddrD=31. alu_ready=mem_ready=0 throughout CLEAR, even with alu_valid=1 held.
- RUN, alu_valid=1 with addr=5, data=0xDEADBEEF, single cycle -> alu_ready=1. Next cycle RegWEn=1, AddrD=5, DataD=0xDEADBEEF. The cycle after, RegWEn=0.
- RUN, both valid for 4 cycles (ALU addr 1..4 data 0x10..0x40, MEM addr 8..11 data 0x80..0xB0, each advancing only on its own acceptance) -> grant order ALU(1), MEM(8), ALU(2), MEM(9). RegWEn stays high for 4 consecutive cycles. The losing side holds its values stable.
- RUN, mem_valid=1 with addr=0, data=0x1234 -> mem_ready=1 and RegWEn=0 next cycle. rr_prio flips to ALU, checked by a subsequent dual request granting ALU first.
- Assert rst at clear address 17, release, then idle -> outputs zero asynchronously. Clear restarts at AddrD=0 and runs a full 32 writes before init_done=1.
- Assert rst in RUN in the same cycle an ALU request is accepted -> RegWEn=0 immediately. The clear sequence restarts and the accepted write never appears on the port.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Imported by the round-robin arbiter and the writeback port owner.
package regfile_pkg;

  typedef enum logic {
    WB_CLEAR = 1'b0,
    WB_RUN   = 1'b1
  } wbState_t;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  function automatic logic otherReq(input logic req);
    return ~req;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// The priority flop lives in the parent; this block only proposes next_prio.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       grant_taken,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       next_prio
);

  always_comb begin
    gnt       = 2'b00;
    next_prio = prio;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio == REQ_ALU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    // The winner drops to lowest priority; an idle cycle leaves priority alone.
    if (grant_taken && (gnt != 2'b00)) begin
      next_prio = otherReq(gnt[0] ? REQ_ALU : REQ_MEM);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: clears every register after reset,
// then shares the port between ALU and load writeback with round-robin.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int                 ADDR_W      = REG_ADDR_W,
  parameter int                 DATA_W      = REG_DATA_W,
  parameter int                 NUM_REGS    = 32,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              RegWEn,
  output logic [ADDR_W-1:0] AddrD,
  output logic [DATA_W-1:0] DataD,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] X0_ADDR   = ADDR_W'(REG_X0);

  wbState_t          state;
  wbState_t          stateNext;
  logic [ADDR_W-1:0] clrPtr;
  logic              rrPrio;
  logic              rrPrioNext;
  logic              inRun;
  logic [1:0]        reqGated;
  logic [1:0]        gnt;
  logic              granted;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;

  rr_arb2 uArb (
    .req         (reqGated),
    .grant_taken (inRun),
    .prio        (rrPrio),
    .gnt         (gnt),
    .next_prio   (rrPrioNext)
  );

  always_comb begin
    inRun     = (state == WB_RUN);
    reqGated  = inRun ? {mem_valid, alu_valid} : 2'b00;
    alu_ready = gnt[0];
    mem_ready = gnt[1];
    granted   = (gnt != 2'b00);
    selAddr   = gnt[1] ? mem_addr : alu_addr;
    selData   = gnt[1] ? mem_data : alu_data;
  end

  always_comb begin
    stateNext = state;
    if ((state == WB_CLEAR) && (clrPtr == LAST_ADDR)) begin
      stateNext = WB_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WB_CLEAR;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clrPtr    <= '0;
      rrPrio    <= REQ_ALU;
      RegWEn    <= 1'b0;
      AddrD     <= '0;
      DataD     <= '0;
      init_done <= 1'b0;
    end else if (state == WB_CLEAR) begin
      RegWEn <= 1'b1;
      AddrD  <= clrPtr;
      DataD  <= CLEAR_VALUE;
      clrPtr <= clrPtr + 1'b1;
    end else begin
      init_done <= 1'b1;
      rrPrio    <= rrPrioNext;
      if (granted) begin
        // x0 is hard-wired after the clear: the request is consumed but never written.
        RegWEn <= (selAddr != X0_ADDR);
        AddrD  <= selAddr;
        DataD  <= selData;
      end else begin
        RegWEn <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a transaction-level model is checked
// against the DUT on every negedge, plus literal expectations per scenario.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        RegWEn;
  logic [4:0]  AddrD;
  logic [31:0] DataD;
  logic        init_done;

  int nChecks = 0;
  int nPass = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .RegWEn    (RegWEn),
    .AddrD     (AddrD),
    .DataD     (DataD),
    .init_done (init_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: clear writes counted up to 32, then a priority pointer that flips on every grant.
  int          mClr;
  logic        mPrio;
  logic        mWe;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  logic        mInit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mClr <= 0; mPrio <= 1'b0; mWe <= 1'b0; mAddr <= '0; mData <= '0; mInit <= 1'b0;
    end else if (mClr < 32) begin
      mWe <= 1'b1; mAddr <= mClr[4:0]; mData <= '0; mClr <= mClr + 1;
    end else begin
      mInit <= 1'b1;
      if (alu_valid && (!mem_valid || !mPrio)) begin
        mWe <= (alu_addr != 0); mAddr <= alu_addr; mData <= alu_data; mPrio <= 1'b1;
      end else if (mem_valid) begin
        mWe <= (mem_addr != 0); mAddr <= mem_addr; mData <= mem_data; mPrio <= 1'b0;
      end else begin
        mWe <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc RegWEn", 64'(RegWEn), 64'(mWe));
    chk("cyc AddrD", 64'(AddrD), 64'(mAddr));
    chk("cyc DataD", 64'(DataD), 64'(mData));
    chk("cyc init_done", 64'(init_done), 64'(mInit));
    chk("cyc alu_ready", 64'(alu_ready), 64'((mClr >= 32) && alu_valid && (!mem_valid || !mPrio)));
    chk("cyc mem_ready", 64'(mem_ready), 64'((mClr >= 32) && mem_valid && (!alu_valid || mPrio)));
  end

  // Requesters must hold valid, addr and data while waiting for ready.
  logic        pAV, pAR, pMV, pMR;
  logic [4:0]  pAA, pMA;
  logic [31:0] pAD, pMD;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pAV <= 1'b0; pMV <= 1'b0; pAR <= 1'b0; pMR <= 1'b0;
    end else begin
      if (pAV && !pAR) begin
        chk("alu hold", 64'({alu_valid, alu_addr, alu_data}), 64'({1'b1, pAA, pAD}));
      end
      if (pMV && !pMR) begin
        chk("mem hold", 64'({mem_valid, mem_addr, mem_data}), 64'({1'b1, pMA, pMD}));
      end
      pAV <= alu_valid; pAR <= alu_ready; pAA <= alu_addr; pAD <= alu_data;
      pMV <= mem_valid; pMR <= mem_ready; pMA <= mem_addr; pMD <= mem_data;
    end
  end

  int          cyc = 0;
  logic        logEn = 1'b0;
  logic [4:0]  wrLog[$];
  int          wrCyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (logEn && RegWEn) begin
      wrLog.push_back(AddrD);
      wrCyc.push_back(cyc);
    end
  end

  // Drives one request from posedge+1 until accepted; returns cycles waited.
  task automatic sendOne(input logic isMem, input logic [4:0] addr, input logic [31:0] data,
                         output int waited);
    logic r;
    waited = 0;
    @(posedge clk); #1;
    if (isMem) begin mem_valid = 1'b1; mem_addr = addr; mem_data = data; end
    else begin alu_valid = 1'b1; alu_addr = addr; alu_data = data; end
    r = 1'b0;
    while (!r && waited < 20) begin
      @(negedge clk);
      r = isMem ? mem_ready : alu_ready;
      @(posedge clk); #1;
      waited++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    if (!r) chk("send timeout", 64'(waited), 64'(0));
  endtask

  logic [4:0] expLog [8];
  initial begin
    expLog[0] = 5'd1; expLog[1] = 5'd8; expLog[2] = 5'd2;  expLog[3] = 5'd9;
    expLog[4] = 5'd3; expLog[5] = 5'd10; expLog[6] = 5'd4; expLog[7] = 5'd11;
  end

  initial begin
    int   n;
    int   aIdx;
    int   mIdx;
    int   wrCount;
    logic ar, mr;
    logic bad;
    logic found;
    logic seenInit;

    repeat (2) @(posedge clk);
    #1;
    chk("reset RegWEn", 64'(RegWEn), 64'(0));
    chk("reset AddrD", 64'(AddrD), 64'(0));
    chk("reset init_done", 64'(init_done), 64'(0));
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
    #1;
    chk("reset alu_ready", 64'(alu_ready), 64'(0));

    // Clear with an ALU request held throughout.
    @(negedge clk); #2 rst = 1'b0;
    bad = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i < 32 && (alu_ready !== 1'b0 || mem_ready !== 1'b0)) bad = 1'b1;
      if (i == 1) chk("first clear addr", 64'(AddrD), 64'(0));
      if (i == 32) begin
        chk("last clear addr", 64'(AddrD), 64'(31));
        chk("init low on last clear", 64'(init_done), 64'(0));
        chk("ready in first run cycle", 64'(alu_ready), 64'(1));
      end
    end
    chk("ready low during clear", 64'(bad), 64'(0));
    @(posedge clk); #1 alu_valid = 1'b0;
    @(negedge clk);
    chk("init after clear", 64'(init_done), 64'(1));
    chk("held req write", 64'({RegWEn, AddrD, DataD}), 64'({1'b1, 5'd7, 32'h77}));

    // Single ALU write.
    sendOne(1'b0, 5'd5, 32'hDEADBEEF, n);
    chk("alu single latency", 64'(n), 64'(1));
    @(negedge clk);
    chk("alu single write", 64'({RegWEn, AddrD, DataD}), 64'({1'b1, 5'd5, 32'hDEADBEEF}));
    @(negedge clk);
    chk("alu single idle", 64'({RegWEn, AddrD, DataD}), 64'({1'b0, 5'd5, 32'hDEADBEEF}));

    // Load to x0: consumed without a write.
    sendOne(1'b1, 5'd0, 32'h1234, n);
    chk("x0 latency", 64'(n), 64'(1));
    @(negedge clk);
    chk("x0 no write", 64'(RegWEn), 64'(0));

    // Dual requests, each side advancing only on its own acceptance.
    wrLog.delete(); wrCyc.delete();
    logEn = 1'b1;
    aIdx = 0; mIdx = 0; n = 0;
    @(posedge clk); #1;
    while ((aIdx < 4 || mIdx < 4) && n < 30) begin
      alu_valid = (aIdx < 4); alu_addr = 5'(1 + aIdx); alu_data = 32'((aIdx + 1) * 16);
      mem_valid = (mIdx < 4); mem_addr = 5'(8 + mIdx); mem_data = 32'(8'h80 + 16 * mIdx);
      @(negedge clk);
      ar = alu_ready; mr = mem_ready;
      @(posedge clk); #1;
      if (ar) aIdx++;
      if (mr) mIdx++;
      n++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("dual cycles", 64'(n), 64'(8));
    repeat (2) @(negedge clk);
    logEn = 1'b0;
    chk("dual write count", 64'(wrLog.size()), 64'(8));
    if (wrLog.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("dual grant order", 64'(wrLog[i]), 64'(expLog[i]));
      chk("dual no bubbles", 64'(wrCyc[7] - wrCyc[0]), 64'(7));
    end

    // Reset in the middle of the clear at address 17.
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (RegWEn && AddrD == 5'd17) found = 1'b1;
    end
    chk("reach clear addr 17", 64'(found), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", 64'({RegWEn, AddrD, DataD, init_done}), 64'(0));
    @(negedge clk); #2 rst = 1'b0;
    wrCount = 0; seenInit = 1'b0;
    for (int i = 0; i < 40 && !seenInit; i++) begin
      @(negedge clk);
      if (i == 0) chk("restart clear addr", 64'(AddrD), 64'(0));
      if (init_done) seenInit = 1'b1;
      else if (RegWEn) wrCount++;
    end
    chk("restart init", 64'(seenInit), 64'(1));
    chk("restart clear writes", 64'(wrCount), 64'(32));

    // Reset in the same cycle as an ALU acceptance.
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 32'hCAFE0013;
    @(negedge clk);
    chk("accept before reset", 64'(alu_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1; alu_valid = 1'b0;
    #1;
    chk("reset drops write", 64'(RegWEn), 64'(0));
    @(negedge clk); #2 rst = 1'b0;
    wrCount = 0; seenInit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (RegWEn && DataD == 32'hCAFE0013) wrCount++;
      if (init_done) seenInit = 1'b1;
    end
    chk("dropped write absent", 64'(wrCount), 64'(0));
    chk("clear after run reset", 64'(seenInit), 64'(1));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", nPass, nChecks);
    $fatal(1);
  end

endmodule
